// File: rtl/program_loader_if.sv
// program_loader_if: host handshake, RAM write port and status bus; slave modport faces the loader, master faces host/RAM/CPU side
interface program_loader_if #(
  parameter int RAM_BYTES = 16
);
  localparam int AW = $clog2(RAM_BYTES);
  localparam int CW = $clog2(RAM_BYTES + 1);
  logic          load_mode;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ack;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic          ram_we;
  logic          cpu_hold;
  logic [CW-1:0] byte_count;
  logic          done;
  logic          err;
  modport slave (
    input  load_mode, in_valid, in_data,
    output in_ack, ram_addr, ram_data, ram_we, cpu_hold, byte_count, done, err
  );
  modport master (
    output load_mode, in_valid, in_data,
    input  in_ack, ram_addr, ram_data, ram_we, cpu_hold, byte_count, done, err
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: loads RAM_BYTES host bytes into RAM via synchronized 4-phase handshake while holding the CPU; ports clk, rst, bus (slave)
module program_loader #(
  parameter int RAM_BYTES = 16
) (
  input logic            clk,
  input logic            rst,
  program_loader_if.slave bus
);
  localparam int AW = $clog2(RAM_BYTES);
  localparam int CW = $clog2(RAM_BYTES + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RAM_BYTES);
  typedef enum logic [2:0] {IDLE, WAIT, WRITE, ACK, FULL} state_t;
  state_t state;
  logic lm_m, lm_s, v_m, v_s, armed;
  always_ff @(posedge clk) begin
    if (rst) begin
      {lm_m, lm_s, v_m, v_s, armed} <= '0;
      state <= IDLE;
      bus.in_ack <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_data <= '0;
      bus.ram_we <= 1'b0;
      bus.cpu_hold <= 1'b0;
      bus.byte_count <= '0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      lm_m <= bus.load_mode;
      lm_s <= lm_m;
      v_m <= bus.in_valid;
      v_s <= v_m;
      bus.ram_we <= 1'b0;
      case (state)
        IDLE: if (lm_s) begin
          state <= WAIT;
          armed <= 1'b0;
          bus.byte_count <= '0;
          bus.done <= 1'b0;
          bus.err <= 1'b0;
          bus.cpu_hold <= 1'b1;
        end
        WAIT: if (!lm_s) begin
          state <= IDLE;
          bus.cpu_hold <= 1'b0;
        end else if (v_s && armed) begin
          state <= WRITE;
          bus.ram_data <= bus.in_data;
          bus.ram_addr <= bus.byte_count[AW-1:0];
          bus.ram_we <= 1'b1;
        end else if (!v_s) begin
          armed <= 1'b1;
        end
        WRITE: begin
          state <= ACK;
          bus.byte_count <= bus.byte_count + CW'(1);
          bus.in_ack <= 1'b1;
        end
        ACK: if (!v_s) begin
          bus.in_ack <= 1'b0;
          state <= (bus.byte_count == FULL_CNT) ? FULL : WAIT;
          bus.done <= (bus.byte_count == FULL_CNT);
        end
        FULL: if (!lm_s) begin
          state <= IDLE;
          bus.cpu_hold <= 1'b0;
          bus.in_ack <= 1'b0;
        end else begin
          bus.in_ack <= v_s;
          bus.err <= bus.err | v_s;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
